// File: rtl/operand_stack_if.sv
// operand_stack_if: command/data bus between a stack user and the operand stack
interface operand_stack_if #(parameter int WIDTH = 16, parameter int DEPTH = 16);
  logic [2:0]               op;
  logic [WIDTH-1:0]         push_data;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic [$clog2(DEPTH):0]   depth;
  logic                     empty;
  logic                     full;
  logic                     err_over;
  logic                     err_under;
  modport master (output op, push_data, input a, b, depth, empty, full, err_over, err_under);
  modport slave  (input op, push_data, output a, b, depth, empty, full, err_over, err_under);
endinterface

// File: rtl/operand_stack.sv
// operand_stack: register-file operand stack with ALU-oriented commands and sticky error flags
module operand_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input logic            clk,
  input logic            rst,
  operand_stack_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] PUSH = 3'd1, POP = 3'd2, BINOP = 3'd3, UNOP = 3'd4, DUP = 3'd5, SWAP = 3'd6;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      sp, sp_next;
  logic [AW-1:0]    top, sec, nxt;
  logic [WIDTH-1:0] a, b;
  logic             empty, full, two, over, under, ok, err_over, err_under;
  assign top   = AW'(sp - 1'b1);
  assign sec   = AW'(sp - 2'd2);
  assign nxt   = sp[AW-1:0];
  assign empty = (sp == '0);
  assign full  = (sp == (AW+1)'(DEPTH));
  assign two   = (sp >= (AW+1)'(2));
  assign a     = empty ? '0 : mem[top];
  assign b     = two ? mem[sec] : '0;
  assign s.a         = a;
  assign s.b         = b;
  assign s.depth     = sp;
  assign s.empty     = empty;
  assign s.full      = full;
  assign s.err_over  = err_over;
  assign s.err_under = err_under;
  // refused commands leave the pointer alone; accepted ones move it by at most one
  always_comb begin
    over    = (s.op == PUSH || s.op == DUP) && full;
    under   = ((s.op == POP || s.op == UNOP || s.op == DUP) && empty) || ((s.op == BINOP || s.op == SWAP) && !two);
    ok      = !over && !under;
    sp_next = !ok ? sp : (s.op == PUSH || s.op == DUP) ? sp + 1'b1 : (s.op == POP || s.op == BINOP) ? sp - 1'b1 : sp;
  end
  // pointer and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      err_over  <= 1'b0;
      err_under <= 1'b0;
    end else begin
      sp        <= sp_next;
      err_over  <= err_over | over;
      err_under <= err_under | under;
    end
  end
  // entry writes; contents are never cleared, the pointer alone defines validity
  always_ff @(posedge clk) begin
    if (!rst && ok)
      case (s.op)
        PUSH:    mem[nxt] <= s.push_data;
        DUP:     mem[nxt] <= a;
        BINOP:   mem[sec] <= s.push_data;
        UNOP:    mem[top] <= s.push_data;
        SWAP:    begin mem[top] <= b; mem[sec] <= a; end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed and random command checking of operand_stack against a queue model
module tb_operand_stack;
  localparam int W = 16, D = 16;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] st[$];
  logic m_over = 1'b0, m_under = 1'b0;
  operand_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();
  operand_stack #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] m_a();
    return st.size() >= 1 ? st[st.size()-1] : '0;
  endfunction
  function automatic logic [W-1:0] m_b();
    return st.size() >= 2 ? st[st.size()-2] : '0;
  endfunction
  task automatic model(input logic [2:0] op, input logic [W-1:0] d);
    logic [W-1:0] t;
    case (op)
      3'd1: if (st.size() == D) m_over = 1'b1; else st.push_back(d);
      3'd2: if (st.size() == 0) m_under = 1'b1; else void'(st.pop_back());
      3'd3: if (st.size() < 2) m_under = 1'b1; else begin void'(st.pop_back()); void'(st.pop_back()); st.push_back(d); end
      3'd4: if (st.size() == 0) m_under = 1'b1; else st[st.size()-1] = d;
      3'd5: if (st.size() == 0) m_under = 1'b1; else if (st.size() == D) m_over = 1'b1; else st.push_back(st[st.size()-1]);
      3'd6: if (st.size() < 2) m_under = 1'b1; else begin t = st[st.size()-1]; st[st.size()-1] = st[st.size()-2]; st[st.size()-2] = t; end
      default: ;
    endcase
  endtask
  task automatic cmd(input logic [2:0] op, input logic [W-1:0] d);
    @(negedge clk);
    bus.op = op;
    bus.push_data = d;
    @(posedge clk);
    model(op, d);
    #1 bus.op = 3'd0;
    bus.push_data = 16'h5A5A;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    st.delete();
    m_over = 1'b0;
    m_under = 1'b0;
    bus.op = 3'd1;
    bus.push_data = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    bus.op = 3'd0;
    rst = 1'b0;
  endtask
  // every settled cycle out of reset, the DUT must agree with the queue model
  always @(negedge clk) begin
    if (!rst) begin
      chk("a", 32'(bus.a), 32'(m_a()));
      chk("b", 32'(bus.b), 32'(m_b()));
      chk("depth", 32'(bus.depth), 32'(st.size()));
      chk("empty", 32'(bus.empty), 32'(st.size() == 0));
      chk("full", 32'(bus.full), 32'(st.size() == D));
      chk("err_over", 32'(bus.err_over), 32'(m_over));
      chk("err_under", 32'(bus.err_under), 32'(m_under));
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.op = 3'd0;
    bus.push_data = '0;
    #1;
    chk("rst_depth", 32'(bus.depth), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    do_reset();
    cmd(3'd1, 16'h0006);
    cmd(3'd1, 16'h0009);
    @(negedge clk);
    chk("t1_a", 32'(bus.a), 32'h9);
    chk("t1_b", 32'(bus.b), 32'h6);
    chk("t1_depth", 32'(bus.depth), 2);
    cmd(3'd3, 16'h000F);
    @(negedge clk);
    chk("t1_binop_a", 32'(bus.a), 32'hF);
    chk("t1_binop_b", 32'(bus.b), 0);
    chk("t1_binop_depth", 32'(bus.depth), 1);
    do_reset();
    cmd(3'd1, 16'hDEAD);
    cmd(3'd1, 16'hBEEF);
    cmd(3'd6, 16'h0000);
    @(negedge clk);
    chk("swap_a", 32'(bus.a), 32'hDEAD);
    chk("swap_b", 32'(bus.b), 32'hBEEF);
    cmd(3'd5, 16'h0000);
    @(negedge clk);
    chk("dup_a", 32'(bus.a), 32'hDEAD);
    chk("dup_b", 32'(bus.b), 32'hDEAD);
    chk("dup_depth", 32'(bus.depth), 3);
    do_reset();
    for (int i = 1; i <= 16; i++) cmd(3'd1, 16'(i));
    @(negedge clk);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_a", 32'(bus.a), 32'h10);
    cmd(3'd1, 16'hFFFF);
    @(negedge clk);
    chk("ovf_a", 32'(bus.a), 32'h10);
    chk("ovf_depth", 32'(bus.depth), 16);
    chk("ovf_flag", 32'(bus.err_over), 1);
    cmd(3'd5, 16'h0000);
    cmd(3'd2, 16'h0000);
    @(negedge clk);
    chk("ovf_pop_a", 32'(bus.a), 32'hF);
    chk("ovf_pop_depth", 32'(bus.depth), 15);
    chk("ovf_sticky", 32'(bus.err_over), 1);
    do_reset();
    cmd(3'd2, 16'h0000);
    @(negedge clk);
    chk("und_flag", 32'(bus.err_under), 1);
    chk("und_depth", 32'(bus.depth), 0);
    chk("und_empty", 32'(bus.empty), 1);
    cmd(3'd1, 16'h1111);
    cmd(3'd3, 16'h2222);
    cmd(3'd6, 16'h0000);
    @(negedge clk);
    chk("und_binop_a", 32'(bus.a), 32'h1111);
    chk("und_binop_depth", 32'(bus.depth), 1);
    do_reset();
    cmd(3'd1, 16'hCA11);
    cmd(3'd4, 16'h0000);
    @(negedge clk);
    chk("unop_a", 32'(bus.a), 0);
    chk("unop_depth", 32'(bus.depth), 1);
    cmd(3'd5, 16'h0000);
    cmd(3'd7, 16'h3333);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_depth", 32'(bus.depth), 0);
    chk("async_a", 32'(bus.a), 0);
    chk("async_b", 32'(bus.b), 0);
    chk("async_flags", 32'({bus.err_over, bus.err_under}), 0);
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      logic [2:0] op;
      op = (i % 200 < 60) ? 3'd1 : 3'($urandom_range(0, 7));
      cmd(op, 16'($urandom));
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
